// File: rtl/sr_ff_checker.sv
// ---------------------------------------------------------------------------
// sr_ff_checker
//
// Cycle-level checker for an SR flip-flop. It keeps its own model of what the
// flop should hold, driven by the same S/R stimulus, and compares the flop's
// Q output against that model one cycle later. Mismatches produce a one-cycle
// pulse, a sticky flag and a saturating count. S=R=1 (the forbidden input)
// drops the model to UNKNOWN and is counted separately.
//
// Optional build feature:
//   SR_CHK_QBAR_EN  - when defined, Qbar is also checked against ~exp_q.
//                     Without it, Qbar is accepted but ignored.
//
// Reset is synchronous and active-high. No asynchronous reset path exists.
// ---------------------------------------------------------------------------
module sr_ff_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Qbar,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] inv_cnt
);

  // Model confidence: UNKNOWN until a legal set or reset has been seen.
  typedef enum logic {
    ST_UNKNOWN = 1'b0,
    ST_KNOWN   = 1'b1
  } state_t;

  // The {S,R} pair decoded into the four SR flop commands.
  typedef enum logic [1:0] {
    SR_HOLD    = 2'b00,
    SR_RESET   = 2'b01,
    SR_SET     = 2'b10,
    SR_INVALID = 2'b11
  } sr_cmd_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  sr_cmd_t          sr_cmd;
  logic             q_mismatch;
  logic             qbar_mismatch;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt_inc;
  logic [CNT_W-1:0] inv_cnt_inc;

  // The state bit is itself the flop, so exp_valid stays a registered output.
  assign exp_valid = (state == ST_KNOWN);

  // Decode the stimulus pair into a flop command.
  always_comb begin
    sr_cmd = sr_cmd_t'({S, R});
  end

  // Compare the sampled flop outputs against the model as it stood before
  // this edge; the model update on the same edge does not affect this result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    q_mismatch    = 1'b0;
    qbar_mismatch = 1'b0;
    mismatch      = 1'b0;

    q_mismatch = (Q != exp_q);
`ifdef SR_CHK_QBAR_EN
    qbar_mismatch = (Qbar != ~exp_q);
`else
    qbar_mismatch = 1'b0;
`endif
    // Both outputs wrong on one edge is still a single mismatch event.
    mismatch = en && (state == ST_KNOWN) && (q_mismatch || qbar_mismatch);
  end

`ifndef SR_CHK_QBAR_EN
  // Qbar is part of the port list in every build but only observed when the
  // complementary check is compiled in.
  logic unused_qbar;
  assign unused_qbar = Qbar;
`endif

  // Saturating next values for both counters: they stick at all-ones.
  always_comb begin
    err_cnt_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);
    inv_cnt_inc = (inv_cnt == CNT_MAX) ? inv_cnt : inv_cnt + CNT_W'(1);
  end

  // Model FSM, compare bookkeeping and counters, all updated on one edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the hardware it describes.
    if (rst) begin
      state      <= ST_UNKNOWN;
      exp_q      <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      inv_cnt    <= '0;
    end else if (en) begin
      // Compare result from the pre-edge model.
      err <= mismatch;
      if (mismatch) begin
        err_sticky <= 1'b1;
        err_cnt    <= err_cnt_inc;
      end

      // Model update, independent of the compare above.
      unique case (sr_cmd)
        SR_SET: begin
          exp_q <= 1'b1;
          state <= ST_KNOWN;
        end
        SR_RESET: begin
          exp_q <= 1'b0;
          state <= ST_KNOWN;
        end
        SR_INVALID: begin
          // Real flop output is undefined after S=R=1; stop comparing until a
          // legal command re-establishes the expected value.
          state   <= ST_UNKNOWN;
          inv_cnt <= inv_cnt_inc;
        end
        default: begin
          // SR_HOLD: keep both exp_q and the current confidence.
        end
      endcase
    end else begin
      // Disabled: model and counters frozen, no compare, no pulse.
      err <= 1'b0;
    end
  end

endmodule
